// File: rtl/multi_pattern_driver.sv
// Multi-channel test-pattern source with a registered valid/ready output stream.
// Each channel runs its own accumulator, with a run-time mode, step and level.
module multi_pattern_driver #(
   parameter int NCH = 4,
   parameter int W   = 16,
   parameter int CW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [CW-1:0]    cfg_ch,
   input  logic [2:0]       cfg_mode,
   input  logic [W-1:0]     cfg_step,
   input  logic [W-1:0]     cfg_level,
   output logic [NCH*W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sync
);

   typedef enum logic [2:0] {
      M_RAMP     = 3'd0,
      M_NEG_RAMP = 3'd1,
      M_HALF     = 3'd2,
      M_CONST    = 3'd3,
      M_SQUARE   = 3'd4,
      M_TRIANGLE = 3'd5,
      M_RES6     = 3'd6,
      M_RES7     = 3'd7
   } mode_e;

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   function automatic mode_e reset_mode(input int k);
      case (k)
         0:       return M_RAMP;
         1:       return M_NEG_RAMP;
         2:       return M_HALF;
         3:       return M_CONST;
         default: return M_RAMP;
      endcase
   endfunction

   logic [W-1:0]        acc_q   [NCH];
   logic [W-1:0]        acc_d   [NCH];
   dir_e                dir_q   [NCH];
   dir_e                dir_d   [NCH];
   mode_e               mode_q  [NCH];
   mode_e               mode_d  [NCH];
   logic [W-1:0]        step_q  [NCH];
   logic [W-1:0]        step_d  [NCH];
   logic [W-1:0]        level_q [NCH];
   logic [W-1:0]        level_d [NCH];

   logic [W:0]          sum_u   [NCH];
   logic signed [W:0]   tri_up  [NCH];
   logic signed [W:0]   tri_dn  [NCH];
   logic signed [W:0]   lim_pos [NCH];
   logic [W-1:0]        lim_q   [NCH];
   logic [W-1:0]        lim_d   [NCH];
   logic [W-1:0]        sample  [NCH];
   logic [NCH-1:0]      cfg_hit;
   logic [NCH-1:0]      carry;
   logic [NCH*W-1:0]    sample_flat;

   logic [NCH*W-1:0]    out_data_q;
   logic                out_valid_q;
   logic                out_sync_q;
   logic                adv;

   assign adv       = en && (!out_valid_q || out_ready);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sync  = out_sync_q;

   // A config write overrides the advance of its own channel; the beat is then
   // built from the freshly cleared accumulator and the newly written mode/level.
   always_comb begin
      sample_flat = '0;
      for (int k = 0; k < NCH; k++) begin
         cfg_hit[k]  = cfg_we && (cfg_ch == CW'(k));
         sum_u[k]    = {1'b0, acc_q[k]} + {1'b0, step_q[k]};
         lim_q[k]    = {1'b0, level_q[k][W-2:0]};
         lim_pos[k]  = $signed({1'b0, lim_q[k]});
         tri_up[k]   = $signed({acc_q[k][W-1], acc_q[k]}) + $signed({1'b0, step_q[k]});
         tri_dn[k]   = $signed({acc_q[k][W-1], acc_q[k]}) - $signed({1'b0, step_q[k]});
         acc_d[k]    = acc_q[k];
         dir_d[k]    = dir_q[k];
         mode_d[k]   = mode_q[k];
         step_d[k]   = step_q[k];
         level_d[k]  = level_q[k];
         carry[k]    = 1'b0;

         if (cfg_hit[k]) begin
            mode_d[k]  = mode_e'(cfg_mode);
            step_d[k]  = cfg_step;
            level_d[k] = cfg_level;
            acc_d[k]   = '0;
            dir_d[k]   = DIR_UP;
         end else if (adv) begin
            case (mode_q[k])
               M_RAMP, M_NEG_RAMP, M_HALF, M_SQUARE: begin
                  acc_d[k] = sum_u[k][W-1:0];
                  carry[k] = sum_u[k][W];
               end
               M_TRIANGLE: begin
                  if (dir_q[k] == DIR_UP) begin
                     if (tri_up[k] >= lim_pos[k]) begin
                        acc_d[k] = lim_q[k];
                        dir_d[k] = DIR_DOWN;
                     end else begin
                        acc_d[k] = tri_up[k][W-1:0];
                     end
                  end else begin
                     if (tri_dn[k] <= -lim_pos[k]) begin
                        acc_d[k] = -lim_q[k];
                        dir_d[k] = DIR_UP;
                     end else begin
                        acc_d[k] = tri_dn[k][W-1:0];
                     end
                  end
               end
               default: ;
            endcase
         end

         lim_d[k]  = {1'b0, level_d[k][W-2:0]};
         sample[k] = '0;
         case (mode_d[k])
            M_RAMP, M_TRIANGLE: sample[k] = acc_d[k];
            M_NEG_RAMP:         sample[k] = -acc_d[k];
            M_HALF:             sample[k] = $unsigned($signed(acc_d[k]) >>> 1);
            M_CONST:            sample[k] = level_d[k];
            M_SQUARE:           sample[k] = acc_d[k][W-1] ? -lim_d[k] : lim_d[k];
            default: ;
         endcase
         sample_flat[k*W +: W] = sample[k];
      end
   end

   // Channel state and the output beat only move on an advance or a config write,
   // so a stalled beat and every accumulator hold naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NCH; k++) begin
            acc_q[k]   <= '0;
            dir_q[k]   <= DIR_UP;
            step_q[k]  <= W'(1);
            mode_q[k]  <= reset_mode(k);
            level_q[k] <= (k == 3) ? {1'b0, {(W-1){1'b1}}} : '0;
         end
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sync_q  <= 1'b0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            acc_q[k]   <= acc_d[k];
            dir_q[k]   <= dir_d[k];
            mode_q[k]  <= mode_d[k];
            step_q[k]  <= step_d[k];
            level_q[k] <= level_d[k];
         end
         if (adv) begin
            out_data_q  <= sample_flat;
            out_valid_q <= 1'b1;
            out_sync_q  <= carry[0];
         end else if (out_valid_q && out_ready && !en) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multi_pattern_driver.sv
// Scoreboard bench for multi_pattern_driver: expected beats are queued as stimulus
// is set up and popped whenever the DUT presents a beat that will be accepted.
module tb_multi_pattern_driver;

   localparam int NCH = 4;
   localparam int W   = 16;
   localparam int CW  = 3;
   localparam logic [63:0] ALL = {64{1'b1}};
   localparam logic [63:0] CH0 = 64'h0000_0000_0000_FFFF;

   typedef struct {
      logic [63:0] data;
      logic [63:0] mask;
      logic        sync;
      string       tag;
   } beat_t;

   logic          clk;
   logic          reset;
   logic          en;
   logic          cfg_we;
   logic [CW-1:0] cfg_ch;
   logic [2:0]    cfg_mode;
   logic [W-1:0]  cfg_step;
   logic [W-1:0]  cfg_level;
   logic [63:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_sync;

   beat_t sb[$];
   beat_t e;
   int    compared;
   int    mismatched;

   multi_pattern_driver #(.NCH(NCH), .W(W), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_step  (cfg_step),
      .cfg_level (cfg_level),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sync  (out_sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] beat4(input int c0, input int c1, input int c2, input int c3);
      return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   task automatic push(input logic [63:0] d, input logic [63:0] m, input logic s, input string t);
      beat_t b;
      b.data = d;
      b.mask = m;
      b.sync = s;
      b.tag  = t;
      sb.push_back(b);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      en        = 1'b0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic cfg_write(input int ch, input int mode, input int step, input int level);
      cfg_ch    = CW'(ch);
      cfg_mode  = 3'(mode);
      cfg_step  = 16'(step);
      cfg_level = 16'(level);
      cfg_we    = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      en        = 1'b1;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid);
      end
      compared++;
      if (out_sync !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_sync: got %b, expected 0", out_sync);
      end
      compared++;
      if (out_data !== 64'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: got %h, expected 0", out_data);
      end
      reset = 1'b0;
      en    = 1'b0;
   endtask

   task automatic test_defaults();
      do_reset();
      for (int k = 1; k <= 3; k++) push(beat4(k, -k, k >>> 1, 16'h7FFF), ALL, 1'b0, "defaults");
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL defaults_extra: got data=%h, expected no beat", out_data);
            end else begin
               e = sb.pop_front();
               if ((out_data & e.mask) !== (e.data & e.mask) || out_sync !== e.sync) begin
                  mismatched++;
                  $display("[TB] FAIL %s: got data=%h sync=%b, expected data=%h sync=%b",
                           e.tag, out_data & e.mask, out_sync, e.data & e.mask, e.sync);
               end
            end
         end
      end
      en = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL defaults_missing: got %0d beats left, expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_wrap();
      do_reset();
      cfg_write(0, 0, 16'h4000, 0);
      cfg_write(1, 1, 16'h4000, 0);
      push(beat4(16'h4000, 16'hC000, 0, 16'h7FFF), ALL, 1'b0, "wrap_b1");
      push(beat4(16'h8000, 16'h8000, 1, 16'h7FFF), ALL, 1'b0, "wrap_b2");
      push(beat4(16'hC000, 16'h4000, 1, 16'h7FFF), ALL, 1'b0, "wrap_b3");
      push(beat4(16'h0000, 16'h0000, 2, 16'h7FFF), ALL, 1'b1, "wrap_b4");
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL wrap_extra: got data=%h, expected no beat", out_data);
            end else begin
               e = sb.pop_front();
               if ((out_data & e.mask) !== (e.data & e.mask) || out_sync !== e.sync) begin
                  mismatched++;
                  $display("[TB] FAIL %s: got data=%h sync=%b, expected data=%h sync=%b",
                           e.tag, out_data & e.mask, out_sync, e.data & e.mask, e.sync);
               end
            end
         end
      end
      en = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL wrap_missing: got %0d beats left, expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_triangle();
      int seqA[12] = '{3, 6, 9, 10, 7, 4, 1, -2, -5, -8, -10, -7};
      int seqB[7]  = '{3, 5, 2, -1, -4, -5, -2};
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         int n;
         n = (pass == 0) ? 12 : 7;
         cfg_write(0, 5, 3, (pass == 0) ? 10 : 16'h8005);
         for (int i = 0; i < n; i++)
            push(beat4((pass == 0) ? seqA[i] : seqB[i], 0, 0, 0), CH0, 1'b0,
                 (pass == 0) ? "triangle_l10" : "triangle_l8005");
         en = 1'b1;
         for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_ready) begin
               compared++;
               if (sb.size() == 0) begin
                  mismatched++;
                  $display("[TB] FAIL triangle_extra: got data=%h, expected no beat", out_data);
               end else begin
                  e = sb.pop_front();
                  if ((out_data & e.mask) !== (e.data & e.mask) || out_sync !== e.sync) begin
                     mismatched++;
                     $display("[TB] FAIL %s: got data=%h sync=%b, expected data=%h sync=%b",
                              e.tag, out_data & e.mask, out_sync, e.data & e.mask, e.sync);
                  end
               end
            end
         end
         en = 1'b0;
         @(posedge clk);
         #1;
      end
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL triangle_missing: got %0d beats left, expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_stall();
      logic [63:0] held;
      do_reset();
      for (int k = 1; k <= 10; k++) push(beat4(k, -k, k >>> 1, 16'h7FFF), ALL, 1'b0, "stall_seq");
      held = beat4(4, -4, 2, 16'h7FFF);
      en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         out_ready = !(i >= 3 && i < 8);
         if (!out_ready) begin
            compared++;
            if (out_valid !== 1'b1 || out_data !== held || out_sync !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL stall_hold: got valid=%b data=%h sync=%b, expected valid=1 data=%h sync=0",
                        out_valid, out_data, out_sync, held);
            end
         end
         if (out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL stall_extra: got data=%h, expected no beat", out_data);
            end else begin
               e = sb.pop_front();
               if ((out_data & e.mask) !== (e.data & e.mask) || out_sync !== e.sync) begin
                  mismatched++;
                  $display("[TB] FAIL %s: got data=%h sync=%b, expected data=%h sync=%b",
                           e.tag, out_data & e.mask, out_sync, e.data & e.mask, e.sync);
               end
            end
         end
      end
      en = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL stall_missing: got %0d beats left, expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_cfg_same_cycle();
      int ch2[6] = '{0, 1, 100, -100, 100, -100};
      do_reset();
      for (int k = 1; k <= 6; k++) push(beat4(k, -k, ch2[k-1], 16'h7FFF), ALL, 1'b0, "cfg_same_cycle");
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         cfg_we = 1'b0;
         if (i == 1) begin
            cfg_ch = 3'd2; cfg_mode = 3'd4; cfg_step = 16'h8000; cfg_level = 16'd100; cfg_we = 1'b1;
         end else if (i == 3) begin
            cfg_ch = 3'd7; cfg_mode = 3'd3; cfg_step = 16'd0; cfg_level = 16'd0; cfg_we = 1'b1;
         end
         if (out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL cfg_extra: got data=%h, expected no beat", out_data);
            end else begin
               e = sb.pop_front();
               if ((out_data & e.mask) !== (e.data & e.mask) || out_sync !== e.sync) begin
                  mismatched++;
                  $display("[TB] FAIL %s: got data=%h sync=%b, expected data=%h sync=%b",
                           e.tag, out_data & e.mask, out_sync, e.data & e.mask, e.sync);
               end
            end
         end
      end
      cfg_we = 1'b0;
      en     = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL cfg_missing: got %0d beats left, expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 1; k <= 3; k++)
            push(beat4(k, -k, k >>> 1, 16'h7FFF), ALL, 1'b0, (pass == 0) ? "pre_reset" : "post_reset");
         en        = 1'b1;
         out_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_ready) begin
               compared++;
               if (sb.size() == 0) begin
                  mismatched++;
                  $display("[TB] FAIL midreset_extra: got data=%h, expected no beat", out_data);
               end else begin
                  e = sb.pop_front();
                  if ((out_data & e.mask) !== (e.data & e.mask) || out_sync !== e.sync) begin
                     mismatched++;
                     $display("[TB] FAIL %s: got data=%h sync=%b, expected data=%h sync=%b",
                              e.tag, out_data & e.mask, out_sync, e.data & e.mask, e.sync);
                  end
               end
            end
         end
         if (pass == 0) begin
            out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            compared++;
            if (out_valid !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL midreset_pending: got valid=%b, expected 1", out_valid);
            end
            reset = 1'b1;
            @(posedge clk);
            #1;
            compared++;
            if (out_valid !== 1'b0 || out_data !== 64'h0 || out_sync !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL midreset_clear: got valid=%b data=%h sync=%b, expected valid=0 data=0 sync=0",
                        out_valid, out_data, out_sync);
            end
            reset = 1'b0;
         end
      end
      en = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL midreset_missing: got %0d beats left, expected 0", sb.size());
      end
      sb.delete();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      en         = 1'b0;
      out_ready  = 1'b0;
      cfg_we     = 1'b0;
      cfg_ch     = '0;
      cfg_mode   = '0;
      cfg_step   = '0;
      cfg_level  = '0;
      test_reset();
      test_defaults();
      test_wrap();
      test_triangle();
      test_stall();
      test_cfg_same_cycle();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
